// File: rtl/trigger_pkg.sv
// Shared mode constants and FSM state encoding for the multi-channel trigger generator.
package trigger_pkg;

  localparam logic [1:0] MODE_OR   = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_SHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_WAIT_STOP,
    ST_PULSE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/trig_div_chan.sv
// One programmable divider channel: free-running counter with >= wrap and a registered tick.
module trig_div_chan #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divisor lowered below the current count wraps at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= div) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/trigger_multi_gen.sv
// NCH divider channels feeding a mode-controlled trigger FSM with pulse width and burst count.
module trigger_multi_gen
  import trigger_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned PW_W    = 8,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned SEL_W   = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic [NCH-1:0]     ch_en_i,
  input  logic [SEL_W-1:0]   start_sel_i,
  input  logic [SEL_W-1:0]   stop_sel_i,
  input  logic [1:0]         mode_i,
  input  logic [PW_W-1:0]    pw_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               clr,
  output logic               trig_o,
  output logic [NCH-1:0]     tick_o,
  output logic               busy_o,
  output logic               done_o
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    trig_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (ch_en_i[k]),
      .div   (div_i[k*DIV_W +: DIV_W]),
      .tick  (tick_o[k])
    );
  end

  state_t             state;
  logic [PW_W-1:0]    pw_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [PW_W-1:0]    pw_eff;
  logic [BURST_W-1:0] burst_nxt;
  logic               seq_mode;
  logic               burst_end;

  always_comb begin
    seq_mode  = (mode_i == MODE_SEQ) || (mode_i == MODE_SHOT);
    pw_eff    = (pw_i == '0) ? PW_W'(1) : pw_i;
    burst_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
    burst_end = (mode_i == MODE_SHOT) || ((burst_i != '0) && (burst_nxt == burst_i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_ARMED;
      trig_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pw_cnt    <= '0;
      burst_cnt <= '0;
    end else if (clr) begin
      state     <= ST_ARMED;
      trig_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pw_cnt    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (seq_mode) begin
            if (tick_o[start_sel_i]) begin
              state  <= ST_WAIT_STOP;
              busy_o <= 1'b1;
            end
          end else if (|tick_o) begin
            state  <= ST_PULSE;
            trig_o <= 1'b1;
            busy_o <= 1'b1;
            pw_cnt <= pw_eff;
          end
        end
        // A stop tick coincident with the start tick was seen while still ARMED, so it never lands here
        ST_WAIT_STOP: begin
          if (tick_o[stop_sel_i]) begin
            state  <= ST_PULSE;
            trig_o <= 1'b1;
            pw_cnt <= pw_eff;
          end
        end
        ST_PULSE: begin
          if (pw_cnt <= PW_W'(1)) begin
            trig_o    <= 1'b0;
            busy_o    <= 1'b0;
            burst_cnt <= burst_nxt;
            if (burst_end) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state <= ST_ARMED;
            end
          end else begin
            pw_cnt <= pw_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          trig_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_multi_gen.sv
// Self-checking bench for trigger_multi_gen: directed scenarios plus randomized configurations.
module tb_trigger_multi_gen;

  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] div_i = '0;
  logic [3:0]  ch_en_i = '0;
  logic [1:0]  start_sel_i = '0;
  logic [1:0]  stop_sel_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  pw_i = '0;
  logic [7:0]  burst_i = '0;
  logic        trig_o;
  logic [3:0]  tick_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  // Per-cycle vectors: {done, busy, trig, tick[3:0]}
  logic [6:0] obs  [MAXC];
  logic [6:0] expv [MAXC];

  trigger_multi_gen #(
    .NCH(4), .DIV_W(16), .PW_W(8), .BURST_W(8)
  ) dut (
    .clk(clk), .reset(reset), .div_i(div_i), .ch_en_i(ch_en_i),
    .start_sel_i(start_sel_i), .stop_sel_i(stop_sel_i), .mode_i(mode_i),
    .pw_i(pw_i), .burst_i(burst_i), .clr(clr), .trig_o(trig_o),
    .tick_o(tick_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] en, input logic [1:0] m,
                         input logic [1:0] ss, input logic [1:0] ps,
                         input int pw, input int bu);
    div_i       = {d3[15:0], d2[15:0], d1[15:0], d0[15:0]};
    ch_en_i     = en;
    mode_i      = m;
    start_sel_i = ss;
    stop_sel_i  = ps;
    pw_i        = pw[7:0];
    burst_i     = bu[7:0];
  endtask

  // Clear on edge 0, then capture samples 0..n-1, each taken 1 time unit after its edge
  task automatic run_cap(input int n);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int e = 0; e < n; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      obs[e] = {done_o, busy_o, trig_o, tick_o};
    end
  endtask

  // After a clear, channel k ticks whenever the elapsed edge count is a nonzero multiple of div+1
  function automatic bit is_tick(input int k, input int e);
    int d;
    d = int'(div_i[k*16 +: 16]);
    return ch_en_i[k] && (e > 0) && ((e % (d + 1)) == 0);
  endfunction

  // Event-level reference: search tick timelines for qualifying triggers and lay out pulse windows
  task automatic build_model(input int n);
    int t, s, q, cnt, pwe, first;
    bit seq;
    seq = (mode_i == 2'd1) || (mode_i == 2'd2);
    pwe = (pw_i == 8'd0) ? 1 : int'(pw_i);
    for (int e = 0; e < n; e++) begin
      expv[e] = '0;
      for (int k = 0; k < 4; k++) expv[e][k] = is_tick(k, e);
    end
    t = 1;
    cnt = 0;
    while (t < n) begin
      s = -1;
      q = -1;
      if (seq) begin
        for (int e = t; e < n && s < 0; e++) if (is_tick(int'(start_sel_i), e)) s = e;
        if (s < 0) break;
        for (int e = s + 1; e < n && q < 0; e++) if (is_tick(int'(stop_sel_i), e)) q = e;
        first = s + 1;
        if (q < 0) begin
          for (int e = first; e < n; e++) expv[e][5] = 1'b1;
          break;
        end
      end else begin
        for (int e = t; e < n && q < 0; e++) if (expv[e][3:0] != 4'd0) q = e;
        if (q < 0) break;
        first = q + 1;
      end
      for (int e = first; e <= q + pwe && e < n; e++) expv[e][5] = 1'b1;
      for (int e = q + 1; e <= q + pwe && e < n; e++) expv[e][4] = 1'b1;
      cnt++;
      if (mode_i == 2'd2 || (burst_i != 8'd0 && cnt == int'(burst_i))) begin
        for (int e = q + pwe + 1; e < n; e++) expv[e][6] = 1'b1;
        break;
      end
      t = q + pwe + 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done_o, busy_o, trig_o, tick_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", {done_o, busy_o, trig_o, tick_o}, 7'd0);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_enable;
    int n = 40;
    set_cfg(3, 0, 0, 0, 4'b0001, 2'b00, 2'd0, 2'd0, 2, 0);
    run_cap(n);
    build_model(n);
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL enable cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    checks++;
    if ({obs[4][0], obs[5][4], obs[6][4], obs[7][4]} !== 4'b1110) begin
      errors++;
      $display("FAIL enable_first_pulse got %b exp %b", {obs[4][0], obs[5][4], obs[6][4], obs[7][4]}, 4'b1110);
    end
  endtask

  task automatic test_sequence;
    int n = 80;
    set_cfg(0, 9, 4, 0, 4'b0110, 2'b01, 2'd1, 2'd2, 1, 0);
    run_cap(n);
    build_model(n);
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL sequence cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    // Start at 10 (coincident with a stop tick, ignored), stop at 15, trig at 16
    checks++;
    if ({obs[11][5], obs[11][4], obs[15][4], obs[16][4], obs[16][5]} !== 5'b10011) begin
      errors++;
      $display("FAIL sequence_timing got %b exp %b",
               {obs[11][5], obs[11][4], obs[15][4], obs[16][4], obs[16][5]}, 5'b10011);
    end
  endtask

  task automatic test_burst;
    int n = 60;
    int rises;
    set_cfg(1, 0, 0, 0, 4'b0001, 2'b00, 2'd0, 2'd0, 1, 3);
    run_cap(n);
    build_model(n);
    rises = 0;
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL burst cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
      if (e > 0 && obs[e][4] && !obs[e-1][4]) rises++;
    end
    checks++;
    if (rises != 3 || obs[n-1][6] !== 1'b1) begin
      errors++;
      $display("FAIL burst_count got %0d pulses done=%b exp 3 pulses done=1", rises, obs[n-1][6]);
    end
  endtask

  task automatic test_shot;
    int n = 60;
    int rises;
    set_cfg(2, 3, 0, 0, 4'b0011, 2'b10, 2'd0, 2'd1, 2, 0);
    run_cap(n);
    build_model(n);
    rises = 0;
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL shot cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
      if (e > 0 && obs[e][4] && !obs[e-1][4]) rises++;
    end
    checks++;
    if (rises != 1 || obs[n-1][6] !== 1'b1) begin
      errors++;
      $display("FAIL shot_count got %0d pulses done=%b exp 1 pulse done=1", rises, obs[n-1][6]);
    end
  endtask

  task automatic test_no_retrigger;
    int n = 30;
    set_cfg(0, 0, 0, 0, 4'b0001, 2'b00, 2'd0, 2'd0, 5, 0);
    run_cap(n);
    build_model(n);
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL no_retrigger cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    // Tick at 1: high 2..6, low 7, high 8..12
    checks++;
    if ({obs[6][4], obs[7][4], obs[8][4]} !== 3'b101) begin
      errors++;
      $display("FAIL no_retrigger_gap got %b exp %b", {obs[6][4], obs[7][4], obs[8][4]}, 3'b101);
    end
  endtask

  task automatic test_edges;
    int n = 60;
    set_cfg(3, 0, 0, 0, 4'b0001, 2'b11, 2'd0, 2'd0, 0, 0);
    run_cap(n);
    build_model(n);
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL pw_zero cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    set_cfg(2, 0, 0, 0, 4'b0001, 2'b01, 2'd0, 2'd0, 1, 0);
    run_cap(n);
    build_model(n);
    for (int e = 0; e < n; e++) begin
      checks++;
      if (obs[e] !== expv[e]) begin
        errors++;
        $display("FAIL same_sel cyc %0d got %b exp %b", e, obs[e], expv[e]);
      end
    end
    // Ticks at 3,6,9,12: start 3, stop 6 -> trig 7; start 9, stop 12 -> trig 13
    checks++;
    if ({obs[4][4], obs[7][4], obs[10][4], obs[13][4]} !== 4'b0101) begin
      errors++;
      $display("FAIL same_sel_alt got %b exp %b", {obs[4][4], obs[7][4], obs[10][4], obs[13][4]}, 4'b0101);
    end
  endtask

  task automatic test_div_lower;
    set_cfg(100, 0, 0, 0, 4'b0001, 2'b00, 2'd0, 2'd0, 1, 0);
    run_cap(51);
    div_i[15:0] = 16'd3;
    checks++;
    if (obs[50][0] !== 1'b0) begin
      errors++;
      $display("FAIL div_lower_before got %b exp 0", obs[50][0]);
    end
    for (int e = 51; e <= 55; e++) begin
      @(posedge clk); #1;
      checks++;
      if (tick_o[0] !== ((e == 51) || (e == 55))) begin
        errors++;
        $display("FAIL div_lower cyc %0d got %b exp %b", e, tick_o[0], (e == 51) || (e == 55));
      end
    end
  endtask

  task automatic test_clear;
    set_cfg(0, 6, 0, 0, 4'b0011, 2'b00, 2'd0, 2'd0, 5, 0);
    run_cap(4);
    checks++;
    if (obs[3][4] !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre got trig %b exp 1", obs[3][4]);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if ({done_o, busy_o, trig_o, tick_o} !== 7'd0) begin
      errors++;
      $display("FAIL clear_state got %b exp %b", {done_o, busy_o, trig_o, tick_o}, 7'd0);
    end
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      obs[i] = {done_o, busy_o, trig_o, tick_o};
    end
    checks++;
    if ({obs[1][0], obs[1][4], obs[2][4], obs[4][1], obs[6][1], obs[7][1]} !== 6'b101001) begin
      errors++;
      $display("FAIL clear_restart got %b exp %b",
               {obs[1][0], obs[1][4], obs[2][4], obs[4][1], obs[6][1], obs[7][1]}, 6'b101001);
    end
  endtask

  task automatic test_async_reset;
    set_cfg(0, 9, 4, 0, 4'b0110, 2'b01, 2'd1, 2'd2, 1, 0);
    run_cap(12);
    checks++;
    if (obs[11][5] !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got busy %b exp 1", obs[11][5]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({done_o, busy_o, trig_o, tick_o} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", {done_o, busy_o, trig_o, tick_o}, 7'd0);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_random;
    int n = 200;
    logic [3:0] en;
    for (int it = 0; it < 10; it++) begin
      en = 4'($urandom_range(1, 15));
      set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              en, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 4), $urandom_range(0, 4));
      run_cap(n);
      build_model(n);
      for (int e = 0; e < n; e++) begin
        checks++;
        if (obs[e] !== expv[e]) begin
          errors++;
          $display("FAIL random it %0d cyc %0d got %b exp %b", it, e, obs[e], expv[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_enable;
    test_sequence;
    test_burst;
    test_shot;
    test_no_retrigger;
    test_edges;
    test_div_lower;
    test_clear;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_multi_gen.md
Name: trigger_multi_gen

Overview:
- Parametrised successor to the two-divider trigger block.
- NCH programmable frequency dividers each produce a tick train. Any two channels are selected as start/stop sources.
- A mode-controlled FSM turns the ticks into width-programmable trigger pulses, with an optional burst count and a done flag.
- Sits between the theremin timing/Wishbone control registers and the sampling/trigger consumers.

Parameters:
- NCH, 4, number of divider channels (2..16).
- DIV_W, 16, divisor width per channel.
- PW_W, 8, pulse-width field width.
- BURST_W, 8, burst-count width.
- SEL_W, $clog2(NCH), channel-select width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- div_i  in  NCH*DIV_W  channel k divisor at [k*DIV_W +: DIV_W]; tick period = div+1 cycles.
- ch_en_i  in  NCH  per-channel divider enable.
- start_sel_i  in  SEL_W  start-source channel.
- stop_sel_i  in  SEL_W  stop-source channel.
- mode_i  in  2  00 OR-of-enabled, 01 sequence start->stop, 10 single-shot sequence, 11 treated as 00.
- pw_i  in  PW_W  trigger high time in cycles; 0 treated as 1.
- burst_i  in  BURST_W  triggers before done; 0 = unlimited.
- clr  in  1  synchronous clear.
- trig_o  out  1  registered trigger pulse.
- tick_o  out  NCH  registered one-cycle per-channel ticks.
- busy_o  out  1  high in WAIT_STOP or PULSE.
- done_o  out  1  burst complete; sticky until clr or reset.

Behaviour:
- Reset (reset=0, async):
  - All divider counters = 0, tick_o = 0, trig_o = 0, busy_o = 0, done_o = 0.
  - Burst count = 0, FSM = ARMED.
- clr=1 (sync, highest priority over all events): same values as reset, applied on the next edge.
- Divider k:
  - When ch_en_i[k]=0: counter held at 0, no ticks.
  - When enabled: counter increments each cycle.
  - When counter >= div_i[k]: counter <= 0 and tick_o[k] <= 1 for one cycle.
  - div=0 gives a tick every cycle.
  - The >= compare means lowering div mid-count wraps on the next cycle.
- FSM states: ARMED, WAIT_STOP, PULSE, DONE.
- ARMED, mode 00/11: any tick_o bit set -> PULSE.
- ARMED, mode 01/10: tick_o[start_sel] -> WAIT_STOP.
- WAIT_STOP: tick_o[stop_sel] -> PULSE.
  - The stop tick must occur strictly after the start tick; a stop tick in the same cycle as the start tick is ignored.
  - Further start ticks are ignored, with no restart.
- start_sel == stop_sel: ticks alternate as start, stop, start, ...
- PULSE:
  - trig_o high for max(pw_i,1) cycles, rising on the edge after the qualifying tick_o cycle.
  - pw_i is sampled on PULSE entry.
  - All ticks are ignored; there is no retrigger.
- End of PULSE:
  - Burst count increments.
  - If mode 10, or burst_i != 0 and count == burst_i: -> DONE.
  - Otherwise -> ARMED.
- DONE: trig_o = 0, done_o = 1, ticks ignored, dividers keep running.
- Select and mode inputs are sampled every cycle; changes while in WAIT_STOP take effect immediately.
- Burst counter saturates at all-ones when burst_i = 0.

Decomposition:
- Package trigger_pkg: mode constants (MODE_OR, MODE_SEQ, MODE_SHOT) and the FSM state encoding.
- Sub-module trig_div_chan: one divider with enable, >= wrap and registered tick, generated NCH times.
- Top module holds the FSM, pulse-width counter and burst counter.

Test Plan:
- Reset/enable: NCH=4, div_i ch0=3, ch_en_i=0001, mode 00, pw_i=2 -> tick_o[0] every 4 cycles; each tick gives trig_o high 2 cycles, rising 1 cycle after tick_o.
- Sequence: ch1 div=9, ch2 div=4, start_sel=1, stop_sel=2, mode 01, pw_i=1.
  - trig_o fires 1 cycle after the first ch2 tick strictly following a ch1 tick.
  - busy_o is high from the start tick through the pulse.
  - A coincident ch1/ch2 tick does not fire.
- Burst and single-shot:
  - mode 00, burst_i=3, ch0 div=1 -> exactly 3 pulses, then done_o=1 and trig_o stays 0.
  - Mode 10 -> exactly one pulse, then done_o.
- No retrigger: div=0, pw_i=5, mode 00 -> trig_o high 5 cycles, low 1 cycle (ARMED), high again.
- Clear mid-operation: assert clr during PULSE at cycle 2 of 5 -> next edge trig_o=0, FSM ARMED, counters 0. Async reset low mid-WAIT_STOP -> outputs 0 immediately.
- Edge cases:
  - pw_i=0 -> 1-cycle pulse.
  - start_sel=stop_sel=0, div=2, mode 01 -> trigger on every second ch0 tick.
  - div lowered from 100 to 3 at count 50 -> tick next cycle.
